// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and default timing for the VGA scanout path
// Contents: rgb444_t pixel type, 640x480@60 timing defaults, frame totals,
// frame-store address width and internal counter widths.
package vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CELL_W_DEF   = 20;
    localparam int CELL_H_DEF   = 15;
    localparam int GRID_DEF     = 32;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Frame-store address is {cell_y[4:0], cell_x[4:0]}.
    localparam int ADDR_W     = 10;
    localparam int CELL_IDX_W = ADDR_W / 2;

    localparam int CNT_W      = 10;
    localparam int SUB_W      = 5;
    // One bit wider than the grid index so blanking overrun is detectable.
    localparam int CELL_CNT_W = CELL_IDX_W + 1;

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - horizontal/vertical raster counters and stage-0 sync
// Ports: clk, rst (sync, active high), pix_en (pixel tick);
// h_wrap/v_wrap flag the last pixel/line, v_last_active flags the last
// visible line, active0/hs0/vs0 are combinational from the counters.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic pix_en,
    output logic h_wrap,
    output logic v_wrap,
    output logic v_last_active,
    output logic active0,
    output logic hs0,
    output logic vs0
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    assign h_wrap        = (h_cnt == CNT_W'(H_TOT - 1));
    assign v_wrap        = (v_cnt == CNT_W'(V_TOT - 1));
    assign v_last_active = (v_cnt == CNT_W'(V_ACTIVE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign active0 = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
    assign hs0 = !((h_cnt >= CNT_W'(H_ACTIVE + H_FP)) &&
                   (h_cnt <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs0 = !((v_cnt >= CNT_W'(V_ACTIVE + V_FP)) &&
                   (v_cnt <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA scanout of a 32x32 RGB444 frame store with buffer swap
// Ports: clk, rst (sync, active high), pix_en (pixel tick), frame_ready
// (renderer done), rdata (store data, 1-clk latency); r_addr (store
// address), swap_en/frame_start (1-clk swap pulse), hsync/vsync (active
// low), rgb (pixel colour), miss_cnt (saturating missed-frame count).
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int CELL_W   = CELL_W_DEF,
    parameter int CELL_H   = CELL_H_DEF,
    parameter int GRID     = GRID_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic              frame_ready,
    input  logic [11:0]       rdata,
    output logic [ADDR_W-1:0] r_addr,
    output logic              swap_en,
    output logic              frame_start,
    output logic              hsync,
    output logic              vsync,
    output rgb444_t           rgb,
    output logic [15:0]       miss_cnt
);

    if (GRID * CELL_W != H_ACTIVE) begin : g_bad_h_grid
        $error("GRID*CELL_W must equal H_ACTIVE");
    end
    if (GRID * CELL_H != V_ACTIVE) begin : g_bad_v_grid
        $error("GRID*CELL_H must equal V_ACTIVE");
    end

    logic h_wrap;
    logic v_wrap;
    logic v_last_active;
    logic active0;
    logic hs0;
    logic vs0;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .pix_en        (pix_en),
        .h_wrap        (h_wrap),
        .v_wrap        (v_wrap),
        .v_last_active (v_last_active),
        .active0       (active0),
        .hs0           (hs0),
        .vs0           (vs0)
    );

    logic [SUB_W-1:0]      h_sub,    h_sub_n;
    logic [SUB_W-1:0]      v_sub,    v_sub_n;
    logic [CELL_CNT_W-1:0] cell_x,   cell_x_n;
    logic [CELL_CNT_W-1:0] cell_y,   cell_y_n;
    logic                  addr_ok;
    logic                  vblank_evt;
    logic                  swap_q;

    // Next cell position for the pixel the raster moves to on this tick;
    // sub-counters replace any divide by CELL_W/CELL_H.
    always_comb begin
        h_sub_n  = h_sub;
        cell_x_n = cell_x;
        v_sub_n  = v_sub;
        cell_y_n = cell_y;
        if (h_wrap) begin
            h_sub_n  = '0;
            cell_x_n = '0;
            if (v_wrap) begin
                v_sub_n  = '0;
                cell_y_n = '0;
            end else if (v_sub == SUB_W'(CELL_H - 1)) begin
                v_sub_n  = '0;
                cell_y_n = cell_y + 1'b1;
            end else begin
                v_sub_n  = v_sub + 1'b1;
            end
        end else if (h_sub == SUB_W'(CELL_W - 1)) begin
            h_sub_n  = '0;
            cell_x_n = cell_x + 1'b1;
        end else begin
            h_sub_n  = h_sub + 1'b1;
        end
    end

    assign addr_ok    = (cell_x_n < CELL_CNT_W'(GRID)) && (cell_y_n < CELL_CNT_W'(GRID));
    assign vblank_evt = pix_en && h_wrap && v_last_active;

    // r_addr is loaded with the address of the pixel being entered, so the
    // store's registered rdata is valid by the next tick, when that pixel
    // is pushed through the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_sub  <= '0;
            v_sub  <= '0;
            cell_x <= '0;
            cell_y <= '0;
            r_addr <= '0;
            rgb    <= '0;
            hsync  <= 1'b1;
            vsync  <= 1'b1;
        end else if (pix_en) begin
            h_sub  <= h_sub_n;
            v_sub  <= v_sub_n;
            cell_x <= cell_x_n;
            cell_y <= cell_y_n;
            if (addr_ok) begin
                r_addr <= {cell_y_n[CELL_IDX_W-1:0], cell_x_n[CELL_IDX_W-1:0]};
            end
            rgb   <= active0 ? rgb444_t'(rdata) : '0;
            hsync <= hs0;
            vsync <= vs0;
        end
    end

    // Swap pulse is not gated by pix_en so it lasts exactly one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            swap_q   <= 1'b0;
            miss_cnt <= '0;
        end else begin
            swap_q <= vblank_evt && frame_ready;
            if (vblank_evt && !frame_ready && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end

    assign swap_en     = swap_q;
    assign frame_start = swap_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - directed self-checking bench for vga_scanout
// Scaled raster: 12+2+3+3 = 20 pixels/line, 8+1+2+2 = 13 lines/frame,
// 3x2-pixel cells on a 4x4 grid; store model returns mem[a] = a.
module tb_vga_scanout;

    localparam int HA = 12, HFP = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VFP = 1, VS = 2, VB = 2;
    localparam int CW = 3,  CH = 2,  GR = 4;
    localparam int HT = 20, VT = 13, FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic        frame_ready;
    logic [11:0] rdata;
    logic [9:0]  r_addr;
    logic        swap_en;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic [15:0] miss_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int t = 0;
    logic [9:0] exp_addr = '0;
    int swap_cnt = 0;
    int sw_h = -1;
    int sw_v = -1;

    always #5 clk = ~clk;

    vga_scanout #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VB),
        .CELL_W (CW), .CELL_H (CH), .GRID (GR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .frame_ready (frame_ready),
        .rdata       (rdata),
        .r_addr      (r_addr),
        .swap_en     (swap_en),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .miss_cnt    (miss_cnt)
    );

    always @(posedge clk) rdata <= {2'b00, r_addr};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d)", tag, got, exp, t);
        end
    endtask

    always @(negedge clk) begin
        if (swap_en || frame_start) begin
            chk("frame_start_eq_swap", 32'(frame_start), 32'(swap_en));
            swap_cnt++;
            sw_h = int'(t % HT);
            sw_v = int'((t / HT) % VT);
        end
    end

    task automatic check_state();
        int h, v, ph, pv;
        logic eh, ev;
        logic [11:0] er;
        h = t % HT;
        v = (t / HT) % VT;
        if ((h / CW) < GR && (v / CH) < GR)
            exp_addr = {5'(v / CH), 5'(h / CW)};
        if (t == 0) begin
            eh = 1'b1; ev = 1'b1; er = '0;
        end else begin
            ph = (t - 1) % HT;
            pv = ((t - 1) / HT) % VT;
            eh = !(ph >= HA + HFP && ph < HA + HFP + HS);
            ev = !(pv >= VA + VFP && pv < VA + VFP + VS);
            er = (ph < HA && pv < VA) ? {2'b00, 5'(pv / CH), 5'(ph / CW)} : 12'h000;
        end
        chk("h_cnt", 32'(dut.u_timing.h_cnt), 32'(h));
        chk("v_cnt", 32'(dut.u_timing.v_cnt), 32'(v));
        chk("hsync", 32'(hsync), 32'(eh));
        chk("vsync", 32'(vsync), 32'(ev));
        chk("rgb", 32'(rgb), 32'(er));
        chk("r_addr", 32'(r_addr), 32'(exp_addr));
    endtask

    // One pixel tick every 4 clk; outputs are sampled on the falling edge.
    task automatic run_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_en = 1'b1;
            @(negedge clk);
            pix_en = 1'b0;
            t++;
            check_state();
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pix_en = 1'b0;
        frame_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_raddr", 32'(r_addr), 32'd0);
        chk("rst_swap", 32'(swap_en), 32'd0);
        chk("rst_miss", 32'(miss_cnt), 32'd0);
        rst = 1'b0;
        frame_ready = 1'b1;
        t = 0;
        exp_addr = '0;

        // Frame 0: cell (2,2) pixel check, then a swap at vblank.
        run_ticks(5 * HT + 7 + 1);
        chk("rgb_x7_y5", 32'(rgb), 32'h042);
        run_ticks(VA * HT - (5 * HT + 8) - 1);
        chk("no_swap_before_vblank", 32'(swap_cnt), 32'd0);
        run_ticks(1);
        chk("swap_once", 32'(swap_cnt), 32'd1);
        chk("swap_v", 32'(sw_v), 32'(VA));
        chk("swap_h", 32'(sw_h), 32'd0);
        run_ticks(FT - VA * HT);
        frame_ready = 1'b0;

        // Frames 1..3 missed; a 100-clk stall mid-line in frame 1.
        run_ticks(3 * HT + 5);
        repeat (100) @(negedge clk);
        check_state();
        run_ticks(3 * FT - (3 * HT + 5));
        chk("miss_after_3", 32'(miss_cnt), 32'd3);
        chk("no_swap_on_miss", 32'(swap_cnt), 32'd1);

        // Saturation from 0xFFFE.
        force dut.miss_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.miss_cnt;
        run_ticks(FT);
        chk("miss_ffff", 32'(miss_cnt), 32'hFFFF);
        run_ticks(FT);
        chk("miss_sat", 32'(miss_cnt), 32'hFFFF);

        // Mid-frame reset at line 5 pixel 7, then a full frame with a swap.
        run_ticks(5 * HT + 7);
        @(negedge clk);
        rst = 1'b1;
        pix_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pix_en = 1'b0;
        t = 0;
        exp_addr = '0;
        check_state();
        chk("midrst_swap", 32'(swap_en), 32'd0);
        chk("midrst_miss", 32'(miss_cnt), 32'd0);
        frame_ready = 1'b1;
        @(negedge clk);
        run_ticks(VA * HT - 1);
        chk("midrst_no_early_swap", 32'(swap_cnt), 32'd1);
        run_ticks(1);
        chk("midrst_swap_once", 32'(swap_cnt), 32'd2);
        chk("midrst_swap_v", 32'(sw_v), 32'(VA));
        chk("midrst_swap_h", 32'(sw_h), 32'd0);
        frame_ready = 1'b0;
        run_ticks(FT - VA * HT);
        chk("midrst_miss_after", 32'(miss_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Display-side consumer of the double-buffered 32x32 RGB444 frame store.
- Generates 640x480@60 VGA timing from a pixel-rate enable and issues read addresses to the store's read port.
- Upscales each stored cell to a 20x15-pixel block, drives registered RGB and sync outputs, and requests a buffer swap at the start of vertical blanking when the upstream renderer reports a completed frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CELL_W, 20, horizontal pixels per stored cell
- CELL_H, 15, vertical lines per stored cell
- GRID, 32, cells per row/column; GRID*CELL_W == H_ACTIVE and GRID*CELL_H == V_ACTIVE, checked by elaboration assertion

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel tick; asserts for 1 clk, spaced at least 2 clk apart
- frame_ready  in  1  renderer has finished writing the back buffer; level, held until frame_start
- rdata  in  12  read data from frame store; registered, 1-clk latency from r_addr, store en tied high
- r_addr  out  10  frame store read address {cell_y[4:0], cell_x[4:0]}
- swap_en  out  1  1-clk pulse; swaps front/back buffers
- frame_start  out  1  1-clk pulse, coincident with swap_en; renderer starts the next frame
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- rgb  out  12  pixel colour {r[3:0], g[3:0], b[3:0]}; zero outside the active area
- miss_cnt  out  16  saturating count of vblank starts with frame_ready low

Behaviour:
- Reset (synchronous, any time including mid-frame): next clk sets h_cnt=v_cnt=0, all sub and cell counters 0, r_addr=0, hsync=vsync=1, rgb=0, swap_en=frame_start=0, miss_cnt=0.
- All state advances only on clk edges where pix_en=1; otherwise every register holds. The exceptions are swap_en and frame_start, which self-clear after 1 clk.
- h_cnt runs 0..H_TOTAL-1 (H_TOTAL=800), then wraps to 0. v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1 (525), then wraps to 0.
- Cell counters:
  - h_sub counts 0..CELL_W-1; cell_x increments when h_sub wraps.
  - Both clear when h_cnt wraps.
  - v_sub and cell_y advance likewise per line and clear when v_cnt wraps.
  - No division or multiplication in RTL.
- r_addr = {cell_y, cell_x}, registered from the counters and therefore stable for the whole pixel slot. When cell_x or cell_y would exceed GRID-1 in blanking, r_addr holds its last value.
- Stage-0 signals, combinational from counters:
  - active0 = (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE)
  - hs0 low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vs0 likewise over v_cnt
- Output stage, on pix_en: rgb <= active0 ? rdata : 0; hsync <= hs0; vsync <= vs0. This gives exactly 1 pixel of latency, and all outputs stay aligned.
- Vblank event: the pix_en clk on which the counters move to h_cnt=0, v_cnt=V_ACTIVE.
  - If frame_ready=1: swap_en=1 and frame_start=1 on the following clk, for exactly 1 clk.
  - If frame_ready=0: no pulse and the front buffer repeats; miss_cnt increments and saturates at 0xFFFF.
- frame_ready sampled at any other time has no effect. A swap therefore never occurs in the active area, and at most one swap occurs per frame.

Decomposition:
- Package vga_pkg holds:
  - typedef rgb444_t (12-bit packed struct r/g/b)
  - default timing localparams
  - H_TOTAL/V_TOTAL
  - address width localparam (10)
- Sub-module vga_timing holds h/v counters, stage-0 sync, and active0. vga_scanout adds cell counters, the output stage, and swap/miss logic.

Test Plan:
- Reset then pix_en every 4th clk for 2 frames -> hsync period 800 ticks, low for 96 starting at tick 656+1; vsync low on lines 490-491; 525 lines/frame.
- Store model with mem[a]=a -> at pixel (x=45, y=31) rgb = (2<<5)|2 = 0x042, one tick after the counters reach that pixel; rgb=0 at x=640..799.
- frame_ready=1 before vblank -> single 1-clk swap_en and frame_start at v_cnt 480 h_cnt 0; none elsewhere in the frame.
- frame_ready=0 for 3 frames -> no swap_en, miss_cnt=3; force miss_cnt to 0xFFFE, two more misses -> 0xFFFF.
- pix_en held low 100 clk mid-line -> all outputs and r_addr frozen; resume continues with no skipped pixel.
- rst pulse at line 200 pixel 300 -> next clk hsync=vsync=1, rgb=0, r_addr=0, counters 0; a full frame follows with no swap before v_cnt 480.
